// File: rtl/uart_receiver.sv
// uart_receiver: serial-to-parallel UART receiver, LSB first, 1 stop bit.
// A 2-flop synchronizer feeds a baud counter and a small FSM that samples
// each bit at mid-period and presents the word on a valid/ready register.
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 4096,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_rxd_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
`ifdef UART_RX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [CNT_W-1:0]     bit_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 strobe;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
`endif

  // Sample strobe at the terminal count of the baud counter.
  assign strobe = (bit_cnt == CNT_LAST);

  // Two-flop synchronizer; resets to the idle-high line level so reset
  // release never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make rx_s take the old rx_meta,
      // giving two real flop stages regardless of statement order.
      rx_meta <= uart_rxd_in;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM, baud counter, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= 1'b0;
      par_bad       <= 1'b0;
`endif
    end else begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= 1'b0;
`endif

      // Handshake; a word load later in this block takes priority.
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      // Baud counter free-runs only while a frame is in progress.
      if (state != IDLE && state != BREAK) begin
        bit_cnt <= strobe ? '0 : bit_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            bit_cnt <= CNT_HALF;
            busy    <= 1'b1;
          end
        end

        START: begin
          if (strobe) begin
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        DATA: begin
          if (strobe) begin
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            bit_idx   <= bit_idx + IDX_W'(1);
            if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (strobe) begin
            par_bad <= ^{shift_reg, rx_s};
            state   <= STOP;
          end
        end
`endif

        STOP: begin
          if (strobe) begin
            if (!rx_s) begin
              framing_error <= 1'b1;
              state         <= BREAK;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if (par_bad) begin
                parity_error <= 1'b1;
              end else begin
                data_out   <= shift_reg;
                data_valid <= 1'b1;
                overrun    <= data_valid && !data_ready;
              end
`else
              data_out   <= shift_reg;
              data_valid <= 1'b1;
              overrun    <= data_valid && !data_ready;
`endif
            end
          end
        end

        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed bench for uart_receiver with CLKS_PER_BIT=16,
// DATA_BITS=8. Stimulus changes and output samples happen 1 time unit after
// each rising clock edge; pulse outputs are counted on the falling edge.
module tb_uart_receiver;

  localparam int C = 16;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         uart_rxd_in = 1'b1;
  logic [D-1:0] data_out;
  logic         data_valid;
  logic         data_ready = 1'b0;
  logic         framing_error;
  logic         overrun;
  logic         parity_error;
  logic         busy;

  int total = 0;
  int passed = 0;
  int fails = 0;

  int   fe_cnt = 0;
  int   ov_cnt = 0;
  int   pe_cnt = 0;
  int   dv_rise = 0;
  logic dv_q = 1'b0;

  int fe0, ov0, pe0, dv0;

  uart_receiver #(.CLKS_PER_BIT(C), .DATA_BITS(D)) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rxd_in   (uart_rxd_in),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .overrun       (overrun),
    .parity_error  (parity_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Count one-cycle pulses and data_valid rising edges.
  always @(negedge clk) begin
    if (framing_error) fe_cnt++;
    if (overrun) ov_cnt++;
    if (parity_error) pe_cnt++;
    if (data_valid && !dv_q) dv_rise++;
    dv_q = data_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start bit, data bits LSB first and (when enabled) a correct even-parity
  // bit. The caller drives the stop bit.
  task automatic send_head(input logic [D-1:0] d);
    uart_rxd_in = 1'b0;
    tick(C);
    for (int i = 0; i < D; i++) begin
      uart_rxd_in = d[i];
      tick(C);
    end
`ifdef UART_RX_PARITY_EN
    uart_rxd_in = ^d;
    tick(C);
`endif
  endtask

  task automatic send_frame(input logic [D-1:0] d, input logic stop_bit);
    send_head(d);
    uart_rxd_in = stop_bit;
    tick(C);
  endtask

  task automatic consume();
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_errors", 32'({framing_error, overrun, parity_error}), 32'h0);
    reset = 1'b0;
    tick(4);

    // data_ready with nothing valid is ignored
    data_ready = 1'b1;
    tick(5);
    data_ready = 1'b0;
    check("ready_idle_valid", 32'(data_valid), 32'h0);

    // 0xA5: data_valid rises exactly 155 cycles after the falling edge
    // (171 with parity), holds, then clears after the handshake.
    dv0 = dv_rise;
    send_head(8'hA5);
    uart_rxd_in = 1'b1;
    tick(10);
    check("a5_valid_early", 32'(data_valid), 32'h0);
    tick(1);
    check("a5_valid_rise", 32'(data_valid), 32'h1);
    check("a5_data", 32'(data_out), 32'hA5);
    tick(5 + 20);
    check("a5_hold_valid", 32'(data_valid), 32'h1);
    check("a5_hold_data", 32'(data_out), 32'hA5);
    check("a5_one_rise", 32'(dv_rise - dv0), 32'h1);
    consume();
    check("a5_cleared", 32'(data_valid), 32'h0);

    // 4-cycle low glitch on the idle line is rejected
    fe0 = fe_cnt;
    dv0 = dv_rise;
    uart_rxd_in = 1'b0;
    tick(4);
    check("glitch_busy_start", 32'(busy), 32'h1);
    uart_rxd_in = 1'b1;
    tick(8);
    check("glitch_busy", 32'(busy), 32'h0);
    check("glitch_valid", 32'(data_valid), 32'h0);
    check("glitch_fe", 32'(framing_error), 32'h0);
    check("glitch_fe_cnt", 32'(fe_cnt - fe0), 32'h0);
    check("glitch_no_word", 32'(dv_rise - dv0), 32'h0);
    tick(C);

    // 0x3C with a low stop bit, line held low: one framing error, BREAK
    fe0 = fe_cnt;
    dv0 = dv_rise;
    send_head(8'h3C);
    uart_rxd_in = 1'b0;
    tick(100);
    check("brk_fe_once", 32'(fe_cnt - fe0), 32'h1);
    check("brk_no_word", 32'(dv_rise - dv0), 32'h0);
    check("brk_busy", 32'(busy), 32'h1);
    uart_rxd_in = 1'b1;
    tick(4);
    check("brk_exit_busy", 32'(busy), 32'h0);
    tick(C);
    send_frame(8'h11, 1'b1);
    check("after_brk_valid", 32'(data_valid), 32'h1);
    check("after_brk_data", 32'(data_out), 32'h11);
    check("after_brk_fe", 32'(fe_cnt - fe0), 32'h1);
    consume();

    // Back-to-back 0x01, 0xFE without consuming: overrun on the second
    send_frame(8'h01, 1'b1);
    check("b2b_first_data", 32'(data_out), 32'h01);
    ov0 = ov_cnt;
    send_frame(8'hFE, 1'b1);
    check("b2b_ovr_data", 32'(data_out), 32'hFE);
    check("b2b_ovr_valid", 32'(data_valid), 32'h1);
    check("b2b_ovr_cnt", 32'(ov_cnt - ov0), 32'h1);
    consume();
    check("b2b_ovr_cleared", 32'(data_valid), 32'h0);

    // Same, but accepting in the completion cycle of 0xFE: no overrun
    send_frame(8'h01, 1'b1);
    ov0 = ov_cnt;
    send_head(8'hFE);
    uart_rxd_in = 1'b1;
    tick(10);
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
    check("b2b_acc_valid", 32'(data_valid), 32'h1);
    check("b2b_acc_data", 32'(data_out), 32'hFE);
    tick(5);
    check("b2b_acc_no_ovr", 32'(ov_cnt - ov0), 32'h0);
    consume();

    // Reset mid-DATA of 0x55, then a clean 0x0F
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    pe0 = pe_cnt;
    uart_rxd_in = 1'b0;
    tick(C);
    uart_rxd_in = 1'b1;
    tick(C);
    uart_rxd_in = 1'b0;
    tick(C);
    uart_rxd_in = 1'b1;
    tick(C);
    check("mid_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    tick(1);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_data", 32'(data_out), 32'h0);
    check("mid_rst_valid", 32'(data_valid), 32'h0);
    check("mid_rst_errs", 32'({framing_error, overrun, parity_error}), 32'h0);
    reset = 1'b0;
    uart_rxd_in = 1'b1;
    tick(2 * C);
    send_frame(8'h0F, 1'b1);
    check("post_rst_valid", 32'(data_valid), 32'h1);
    check("post_rst_data", 32'(data_out), 32'h0F);
    check("post_rst_no_err", 32'((fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0)), 32'h0);
    consume();

`ifdef UART_RX_PARITY_EN
    // 0x07 with parity bit 0 (odd total): parity error, word discarded
    pe0 = pe_cnt;
    fe0 = fe_cnt;
    dv0 = dv_rise;
    uart_rxd_in = 1'b0;
    tick(C);
    for (int i = 0; i < D; i++) begin
      uart_rxd_in = (i < 3);
      tick(C);
    end
    uart_rxd_in = 1'b0;
    tick(C);
    uart_rxd_in = 1'b1;
    tick(C + 5);
    check("par_err_cnt", 32'(pe_cnt - pe0), 32'h1);
    check("par_no_word", 32'(dv_rise - dv0), 32'h0);
    check("par_no_fe", 32'(fe_cnt - fe0), 32'h0);
`else
    check("parity_tied_low", 32'(pe_cnt), 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
